// File: rtl/uart_apb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_master_if
// Purpose  : Command/response stream and APB3 requester bundle for uart_apb_master.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_apb_master_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic                      i_req_valid;
    logic                      o_req_ready;
    logic                      i_req_write;
    logic [APB_ADDR_WIDTH-1:0] i_req_addr;
    logic [APB_DATA_WIDTH-1:0] i_req_wdata;

    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic [APB_DATA_WIDTH-1:0] o_rsp_rdata;
    logic                      o_rsp_err;
    logic                      o_rsp_timeout;

    logic [APB_ADDR_WIDTH-1:0] o_apb_paddr;
    logic [APB_DATA_WIDTH-1:0] o_apb_pwdata;
    logic                      o_apb_pwrite;
    logic                      o_apb_psel;
    logic                      o_apb_penable;
    logic [APB_DATA_WIDTH-1:0] i_apb_prdata;
    logic                      i_apb_pready;
    logic                      i_apb_pslverr;

    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        output o_req_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
        input  i_rsp_ready,
        output o_apb_paddr, o_apb_pwdata, o_apb_pwrite, o_apb_psel, o_apb_penable,
        input  i_apb_prdata, i_apb_pready, i_apb_pslverr
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
        output i_rsp_ready,
        input  o_apb_paddr, o_apb_pwdata, o_apb_pwrite, o_apb_psel, o_apb_penable,
        output i_apb_prdata, i_apb_pready, i_apb_pslverr
    );
endinterface
`default_nettype wire

// File: rtl/uart_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_master
// Purpose  : Single-outstanding APB3 requester driven by a valid/ready command
//            stream. Define UART_APB_MASTER_TIMEOUT_EN to enable the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic             i_apb_pclk,
    input  wire logic             i_apb_presetn,
    uart_apb_master_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_done;
    logic                      w_abort;

    logic                      r_req_ready;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_rsp_valid;
    logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      w_wd_expire;

`ifdef UART_APB_MASTER_TIMEOUT_EN
    localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_WD_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_wd_cnt;
    logic               r_rsp_timeout;

    // Expiry is judged on the last permitted ACCESS cycle so the abort edge
    // coincides with the count reaching TIMEOUT_CYCLES.
    assign w_wd_expire = (r_wd_cnt == c_WD_LAST);

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_ACCESS && !bus.i_apb_pready) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_abort) begin
            r_rsp_timeout <= 1'b1;
        end
    end

    assign bus.o_rsp_timeout = r_rsp_timeout;
`else
    assign w_wd_expire       = 1'b0;
    assign bus.o_rsp_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_req_valid) w_state_next = S_SETUP;
            end
            S_SETUP: begin
                w_state_next = S_ACCESS;
            end
            S_ACCESS: begin
                // PREADY on the expiry cycle still completes normally.
                if (bus.i_apb_pready) begin
                    w_state_next = S_RESP;
                    w_done       = 1'b1;
                end else if (w_wd_expire) begin
                    w_state_next = S_RESP;
                    w_abort      = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == S_IDLE);
            r_psel      <= (w_state_next == S_SETUP) || (w_state_next == S_ACCESS);
            r_penable   <= (w_state_next == S_ACCESS);
            r_rsp_valid <= (w_state_next == S_RESP);
        end
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else if (r_state == S_IDLE && bus.i_req_valid) begin
            r_paddr  <= bus.i_req_addr;
            r_pwdata <= bus.i_req_wdata;
            r_pwrite <= bus.i_req_write;
        end
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_done) begin
            r_rsp_rdata <= r_pwrite ? '0 : bus.i_apb_prdata;
            r_rsp_err   <= bus.i_apb_pslverr;
        end else if (w_abort) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
        end
    end

    assign bus.o_req_ready   = r_req_ready;
    assign bus.o_rsp_valid   = r_rsp_valid;
    assign bus.o_rsp_rdata   = r_rsp_rdata;
    assign bus.o_rsp_err     = r_rsp_err;
    assign bus.o_apb_paddr   = r_paddr;
    assign bus.o_apb_pwdata  = r_pwdata;
    assign bus.o_apb_pwrite  = r_pwrite;
    assign bus.o_apb_psel    = r_psel;
    assign bus.o_apb_penable = r_penable;

endmodule
`default_nettype wire

// File: doc/uart_apb_master.md
# uart_apb_master

Synchronous APB3 requester that converts a simple valid/ready command stream into single APB3 transfers toward `uart_top`, and returns read data and status on a valid/ready response channel. It sits directly upstream of the UART's APB3 slave port, replacing bench-task bus driving with synthesizable logic usable by an on-chip controller or a self-checking bench. One transfer is outstanding at a time; an optional watchdog aborts transfers whose slave never asserts PREADY.

## Interface
- `APB_ADDR_WIDTH`, 32: width of request address and `o_apb_paddr`.
- `APB_DATA_WIDTH`, 32: width of write/read data.
- `TIMEOUT_CYCLES`, 256: maximum ACCESS cycles before abort (≥1; used only with the timeout macro).

- `i_apb_pclk` in 1: single clock; all logic is on its rising edge.
- `i_apb_presetn` in 1: reset, asynchronous, active-low.
- `i_req_valid` in 1: command present.
- `o_req_ready` out 1: command accepted when `i_req_valid & o_req_ready`.
- `i_req_write` in 1: 1 = write, 0 = read.
- `i_req_addr` in APB_ADDR_WIDTH: target address.
- `i_req_wdata` in APB_DATA_WIDTH: write data (ignored for reads).
- `o_rsp_valid` out 1: response present.
- `i_rsp_ready` in 1: response consumed when `o_rsp_valid & i_rsp_ready`.
- `o_rsp_rdata` out APB_DATA_WIDTH: captured PRDATA for reads; 0 for writes and timeouts.
- `o_rsp_err` out 1: PSLVERR captured, or timeout.
- `o_rsp_timeout` out 1: transfer aborted by watchdog.
- `o_apb_paddr`, `o_apb_pwdata` out (widths above); `o_apb_pwrite`, `o_apb_psel`, `o_apb_penable` out 1.
- `i_apb_prdata` in APB_DATA_WIDTH; `i_apb_pready`, `i_apb_pslverr` in 1.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- IDLE: `o_req_ready`=1. On handshake latch addr/wdata/write into APB output registers -> SETUP.
- SETUP: `psel`=1, `penable`=0 -> ACCESS unconditionally.
- ACCESS: `psel`=1, `penable`=1. If `i_apb_pready`: capture `i_apb_prdata` (reads only, else 0) and `i_apb_pslverr` into response registers, drop psel/penable -> RESP. Otherwise stay; watchdog counts.
- RESP: `o_rsp_valid`=1, response fields stable until `i_rsp_ready`; on handshake -> IDLE.
- `o_req_ready`=0 in SETUP, ACCESS, RESP; requests are never dropped, only stalled.
- paddr/pwdata/pwrite stable from SETUP through final ACCESS cycle; hold last value after transfer.
- All outputs registered; no combinational input-to-output path.
- Reset (asynchronous, any state, including mid-ACCESS): state IDLE, all outputs 0 except `o_req_ready`=1 after reset release; watchdog counter 0.

## Timing
- Zero-wait-state latency: request handshake edge N; SETUP during N+1; ACCESS N+2; `o_rsp_valid` high from N+3.
- Each PREADY-low ACCESS cycle adds one cycle.
- Maximum throughput: one transfer per 4 cycles when `i_rsp_ready` is held 1; next request is accepted in the cycle after response handshake (IDLE).
- PREADY sampled only in ACCESS; PREADY/PSLVERR in SETUP/IDLE/RESP ignored.

## Configuration
- Macro `UART_APB_MASTER_TIMEOUT_EN`.
- Defined: counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on SETUP, increments each ACCESS cycle with PREADY low; when it reaches TIMEOUT_CYCLES and PREADY is still low, abort: psel/penable drop, RESP with `o_rsp_err`=1, `o_rsp_timeout`=1, `o_rsp_rdata`=0. PREADY high on the same cycle as expiry wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; `o_rsp_timeout` tied 0.

## Test plan
- Write 0x0000_00A5 to addr 0x04, PREADY=1 -> psel at N+1, penable at N+2, rsp_valid at N+3, err=0, rdata=0.
- Read addr 0x08, PREADY low 3 cycles, PRDATA=0x1234_5678 -> ACCESS held 4 cycles, rsp_valid at N+6, rdata=0x1234_5678.
- Read with PSLVERR=1 on completion -> `o_rsp_err`=1, `o_rsp_timeout`=0, next request accepted after response handshake.
- Macro defined, TIMEOUT_CYCLES=8, PREADY stuck 0 -> abort after 8 ACCESS cycles, err=1, timeout=1, rdata=0; macro undefined -> still in ACCESS after 100 cycles.
- `i_rsp_ready`=0 for 5 cycles with `i_req_valid` held -> response fields stable, `o_req_ready`=0 throughout, second request issued only after handshake.
- Assert `i_apb_presetn` low mid-ACCESS -> psel/penable/rsp_valid 0 immediately (no clock edge), FSM IDLE after release.
